// File: rtl/flow_ctrl_buffer.sv
// Ready/valid FIFO buffer with first-word fall-through output, occupancy count,
// almost-full flag and a synchronous flush. Handshake outputs come from registered state.
module flow_ctrl_buffer #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH-1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // Handshake flags depend only on count_q, so no input-to-output paths exist.
  assign ready_in    = (count_q < DEPTH_C);
  assign valid_out   = (count_q != '0);
  assign data_out    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_C);

  assign push = valid_in & ready_in;
  assign pop  = valid_out & ready_out;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_flow_ctrl_buffer.sv
// Directed bench for flow_ctrl_buffer at DATA_W=8, DEPTH=4, AFULL_THRESH=3.
module tb_flow_ctrl_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_in;
  logic       valid_out;
  logic       ready_out;
  logic [7:0] data_out;
  logic [2:0] count;
  logic       almost_full;

  int checks   = 0;
  int failures = 0;

  flow_ctrl_buffer #(.DATA_W(8), .DEPTH(4), .AFULL_THRESH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .data_in    (data_in),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .count      (count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fill_v [4];
  logic [7:0] bp_v   [2];
  logic [7:0] bp_pat;
  int         bp_idx;

  initial begin
    fill_v[0] = 8'h11; fill_v[1] = 8'h22; fill_v[2] = 8'h33; fill_v[3] = 8'h44;
    bp_v[0]   = 8'hA1; bp_v[1]   = 8'hA2;
    bp_pat    = 8'b1001_0100;

    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0; data_in = '0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_ready_in", 32'(ready_in), 1);
    chk("rst_afull", 32'(almost_full), 0);
    #10 rst_n = 1'b1;
    tick();

    // Fill with downstream stalled.
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; data_in = fill_v[i];
      tick();
      chk($sformatf("fill_count%0d", i), 32'(count), 32'(i+1));
      chk($sformatf("fill_afull%0d", i), 32'(almost_full), (i >= 2) ? 32'd1 : 32'd0);
      chk($sformatf("fill_head%0d", i), 32'(data_out), 32'h11);
    end
    chk("full_ready_in", 32'(ready_in), 0);

    // Full with simultaneous pop: the new word must be refused.
    valid_in = 1'b1; data_in = 8'h55; ready_out = 1'b1;
    tick();
    chk("fullpop_count", 32'(count), 3);
    chk("fullpop_ready_in", 32'(ready_in), 1);

    // Drain remaining words in order.
    valid_in = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain_data%0d", i), 32'(data_out), 32'(fill_v[i]));
      tick();
    end
    chk("drain_valid_out", 32'(valid_out), 0);
    chk("drain_count", 32'(count), 0);

    // Empty: ready_out is ignored.
    tick();
    chk("empty_count", 32'(count), 0);
    chk("empty_valid_out", 32'(valid_out), 0);

    // Streaming push+pop every cycle; pointers wrap four times.
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1; ready_out = 1'b1; data_in = 8'(i);
      if (i > 0) chk($sformatf("stream_pre%0d", i), 32'(data_out), 32'(i-1));
      tick();
      chk($sformatf("stream_count%0d", i), 32'(count), 1);
      chk($sformatf("stream_data%0d", i), 32'(data_out), 32'(i));
      chk($sformatf("stream_valid%0d", i), 32'(valid_out), 1);
    end
    valid_in = 1'b0;
    tick();
    chk("stream_end_count", 32'(count), 0);

    // Backpressure stability with count=2.
    ready_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; data_in = bp_v[i];
      tick();
    end
    valid_in = 1'b0;
    chk("bp_count", 32'(count), 2);
    bp_idx = 0;
    for (int i = 0; i < 8; i++) begin
      ready_out = bp_pat[i];
      if (bp_idx < 2) chk($sformatf("bp_data%0d", i), 32'(data_out), 32'(bp_v[bp_idx]));
      else            chk($sformatf("bp_empty%0d", i), 32'(valid_out), 0);
      tick();
      if (ready_out && bp_idx < 2) bp_idx++;
    end
    chk("bp_done_count", 32'(count), 0);

    // Flush beats a concurrent push and pop.
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; data_in = 8'hB1 + 8'(i);
      tick();
    end
    chk("preflush_count", 32'(count), 3);
    flush = 1'b1; valid_in = 1'b1; data_in = 8'hCC; ready_out = 1'b1;
    tick();
    chk("flush_count", 32'(count), 0);
    chk("flush_valid_out", 32'(valid_out), 0);
    chk("flush_ready_in", 32'(ready_in), 1);
    flush = 1'b0; ready_out = 1'b0; data_in = 8'hA5;
    tick();
    chk("postflush_data", 32'(data_out), 32'hA5);
    chk("postflush_count", 32'(count), 1);

    // Async reset between edges with count=2.
    data_in = 8'h5A;
    tick();
    valid_in = 1'b0;
    chk("prereset_count", 32'(count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_count", 32'(count), 0);
    chk("areset_valid_out", 32'(valid_out), 0);
    chk("areset_ready_in", 32'(ready_in), 1);
    chk("areset_afull", 32'(almost_full), 0);
    #2 rst_n = 1'b1;
    valid_in = 1'b1; data_in = 8'h77;
    tick();
    valid_in = 1'b0;
    chk("resume_count", 32'(count), 1);
    chk("resume_data", 32'(data_out), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
